scan_sequencer: RTL and testbench

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_sequencer.sv | 155 +++++++++++++++
 tb/tb_scan_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/scan_sequencer.sv
// scan_sequencer
// Walks a 2-bit channel index across the enabled channels of a 4-channel
// group. A programmable prescaler sets the period between advances.
//
// Ports
//   clk       : single clock, rising-edge active
//   rst_n     : asynchronous active-low reset
//   en        : 1 = run the scan, 0 = idle/hold
//   div       : step period minus one, in clk cycles
//   mask      : per-channel enable, bit i = channel i may be selected
//   dir       : 0 = ascending search, 1 = descending search
//   load      : synchronous strobe that forces sel to load_val
//   load_val  : channel index applied on load
//   sel       : current channel index (feeds a 2-to-4 decoder directly)
//   valid     : sel addresses an enabled channel while running
//   step      : one-cycle pulse with each newly presented sel
//   frame     : one-cycle pulse with step when the advance wrapped
module scan_sequencer #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic [3:0]       mask,
    input  logic             dir,
    input  logic             load,
    input  logic [1:0]       load_val,
    output logic [1:0]       sel,
    output logic             valid,
    output logic             step,
    output logic             frame
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] cnt_next_s;
    logic [1:0]       sel_r;
    logic [1:0]       sel_next_s;
    logic             step_r;
    logic             step_next_s;
    logic             frame_r;
    logic             frame_next_s;
    logic             tick_s;
    logic [1:0]       cand_s;
    logic             wrap_s;

    // Nearest enabled channel from cur in the requested direction; cur itself
    // is returned when no other channel is enabled. Farthest candidate is
    // checked first so the nearest hit overwrites it.
    function automatic logic [1:0] find_next(input logic [1:0] cur,
                                             input logic [3:0] m,
                                             input logic       d);
        logic [1:0] res;
        logic [1:0] cand;
        res = cur;
        for (int k = 3; k >= 1; k--) begin
            cand = d ? (cur - 2'(k)) : (cur + 2'(k));
            if (m[cand]) begin
                res = cand;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: run only while enabled with at least one channel on.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (en && (mask != 4'b0000)) state_next_s = RUN;
                else                         state_next_s = IDLE;
            end
            RUN: begin
                if (!en || (mask == 4'b0000)) state_next_s = IDLE;
                else                          state_next_s = RUN;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM output: valid is combinational on registered state/sel and live mask.
    always_comb begin
        valid = 1'b0;
        if (state_r == RUN) valid = mask[sel_r];
        else                valid = 1'b0;
    end

    // Prescaler compare, channel search and wrap detection.
    always_comb begin
        tick_s = (state_r == RUN) && (cnt_r == div);
        cand_s = find_next(sel_r, mask, dir);
        if (dir) wrap_s = (cand_s >= sel_r);
        else     wrap_s = (cand_s <= sel_r);
    end

    // Datapath next values; load wins over a coincident tick.
    always_comb begin
        cnt_next_s   = cnt_r;
        sel_next_s   = sel_r;
        step_next_s  = 1'b0;
        frame_next_s = 1'b0;
        if (load) begin
            cnt_next_s = {DIV_W{1'b0}};
            sel_next_s = load_val;
        end else if (tick_s) begin
            cnt_next_s   = {DIV_W{1'b0}};
            sel_next_s   = cand_s;
            step_next_s  = 1'b1;
            frame_next_s = wrap_s;
        end else if (state_r == RUN) begin
            // Lowering div below cnt lets cnt run on and wrap naturally.
            cnt_next_s = cnt_r + DIV_W'(1);
        end else begin
            cnt_next_s = {DIV_W{1'b0}};
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= {DIV_W{1'b0}};
            sel_r   <= 2'b00;
            step_r  <= 1'b0;
            frame_r <= 1'b0;
        end else begin
            cnt_r   <= cnt_next_s;
            sel_r   <= sel_next_s;
            step_r  <= step_next_s;
            frame_r <= frame_next_s;
        end
    end

    assign sel   = sel_r;
    assign step  = step_r;
    assign frame = frame_r;

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer: a behavioural model predicts the
// outputs each clock, predictions go through a scoreboard queue and are
// compared one step later; directed scenarios add fixed-value checks.
module tb_scan_sequencer;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] div;
    logic [3:0]  mask;
    logic        dir;
    logic        load;
    logic [1:0]  load_val;
    logic [1:0]  sel;
    logic        valid;
    logic        step;
    logic        frame;

    typedef struct packed {
        logic [1:0] sel;
        logic       step;
        logic       frame;
        logic       valid;
    } exp_t;

    exp_t sb_q[$];

    int n_checks;
    int n_pass;
    int n_step;
    int n_frame;

    // behavioural model state
    logic        m_run;
    logic [15:0] m_cnt;
    logic [1:0]  m_sel;
    logic        m_step;
    logic        m_frame;

    scan_sequencer #(.DIV_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .div(div), .mask(mask),
        .dir(dir), .load(load), .load_val(load_val),
        .sel(sel), .valid(valid), .step(step), .frame(frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_cnt = 16'd0; m_sel = 2'd0; m_step = 1'b0; m_frame = 1'b0;
    endtask

    // Apply one rising edge to the model using the current inputs.
    task automatic model_step();
        logic       tk;
        logic       nr;
        int         ns;
        int         cand;
        bit         found;
        tk = m_run && (m_cnt == div);
        nr = en && (mask != 4'b0000);
        if (load) begin
            m_sel = load_val; m_cnt = 16'd0; m_step = 1'b0; m_frame = 1'b0;
        end else if (tk) begin
            ns = int'(m_sel);
            found = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                cand = dir ? (int'(m_sel) + 4 - k) % 4 : (int'(m_sel) + k) % 4;
                if (!found && mask[cand]) begin
                    ns = cand;
                    found = 1'b1;
                end
            end
            m_frame = dir ? (ns >= int'(m_sel)) : (ns <= int'(m_sel));
            m_step = 1'b1;
            m_sel = 2'(ns);
            m_cnt = 16'd0;
        end else begin
            m_step = 1'b0; m_frame = 1'b0;
            m_cnt = m_run ? m_cnt + 16'd1 : 16'd0;
        end
        m_run = nr;
    endtask

    // One clock: predict, queue, then compare just after the edge.
    task automatic run_cycle();
        exp_t e;
        @(posedge clk);
        model_step();
        e.sel = m_sel; e.step = m_step; e.frame = m_frame;
        e.valid = m_run && mask[m_sel];
        sb_q.push_back(e);
        #1;
        e = sb_q.pop_front();
        check_eq("sel", 32'(sel), 32'(e.sel));
        check_eq("step", 32'(step), 32'(e.step));
        check_eq("frame", 32'(frame), 32'(e.frame));
        check_eq("valid", 32'(valid), 32'(e.valid));
        if (step) n_step++;
        if (frame) n_frame++;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic do_load(input logic [1:0] v);
        load = 1'b1; load_val = v;
        run_cycle();
        load = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; n_step = 0; n_frame = 0;
        rst_n = 1'b0; en = 1'b1; div = 16'd3; mask = 4'b1111; dir = 1'b0;
        load = 1'b0; load_val = 2'd0;
        model_reset();
        #12;
        check_eq("rst_sel", 32'(sel), 32'd0);
        check_eq("rst_step", 32'(step), 32'd0);
        check_eq("rst_frame", 32'(frame), 32'd0);
        check_eq("rst_valid", 32'(valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic ascending scan, div=3
        n_step = 0; n_frame = 0;
        run_cycles(20);
        check_eq("basic_steps", 32'(n_step), 32'd4);
        check_eq("basic_frames", 32'(n_frame), 32'd1);
        check_eq("basic_sel", 32'(sel), 32'd0);

        // skip and reverse: 3,1,3,1 every cycle
        div = 16'd0; mask = 4'b1010; dir = 1'b1;
        do_load(2'd3);
        check_eq("rev_load_sel", 32'(sel), 32'd3);
        n_step = 0; n_frame = 0;
        run_cycles(8);
        check_eq("rev_steps", 32'(n_step), 32'd8);
        check_eq("rev_frames", 32'(n_frame), 32'd4);

        // single channel
        div = 16'd1; mask = 4'b0100; dir = 1'b0;
        do_load(2'd2);
        n_step = 0; n_frame = 0;
        run_cycles(8);
        check_eq("single_steps", 32'(n_step), 32'd4);
        check_eq("single_frames", 32'(n_frame), 32'd4);
        check_eq("single_sel", 32'(sel), 32'd2);
        check_eq("single_valid", 32'(valid), 32'd1);

        // load versus coincident tick
        div = 16'd2; mask = 4'b1111;
        do_load(2'd2);
        run_cycles(2);
        do_load(2'd1);
        check_eq("ldtick_sel", 32'(sel), 32'd1);
        check_eq("ldtick_step", 32'(step), 32'd0);
        n_step = 0;
        run_cycles(2);
        check_eq("ldtick_quiet", 32'(n_step), 32'd0);
        run_cycle();
        check_eq("ldtick_step2", 32'(step), 32'd1);
        check_eq("ldtick_sel2", 32'(sel), 32'd2);

        // mask drop, then re-entry on a disabled channel
        mask = 4'b0000;
        run_cycle();
        check_eq("mask0_sel", 32'(sel), 32'd2);
        run_cycle();
        check_eq("mask0_valid", 32'(valid), 32'd0);
        en = 1'b0; mask = 4'b0001; div = 16'd1;
        do_load(2'd2);
        en = 1'b1;
        run_cycles(2);
        check_eq("reentry_valid", 32'(valid), 32'd0);
        run_cycle();
        check_eq("reentry_sel", 32'(sel), 32'd0);
        check_eq("reentry_valid2", 32'(valid), 32'd1);

        // en dropped mid-period discards the partial count
        mask = 4'b1111; div = 16'd3;
        run_cycles(6);
        en = 1'b0;
        run_cycles(2);
        en = 1'b1;
        run_cycles(10);

        // asynchronous reset between edges mid-scan
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("arst_sel", 32'(sel), 32'd0);
        check_eq("arst_step", 32'(step), 32'd0);
        check_eq("arst_frame", 32'(frame), 32'd0);
        check_eq("arst_valid", 32'(valid), 32'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
        n_step = 0; n_frame = 0;
        run_cycles(4);
        check_eq("arst_quiet", 32'(n_step + n_frame), 32'd0);
        run_cycle();
        check_eq("arst_first_step", 32'(step), 32'd1);

        // random traffic against the model
        for (int i = 0; i < 200; i++) begin
            en       = ($urandom_range(0, 7) != 0);
            mask     = 4'($urandom_range(0, 15));
            dir      = 1'($urandom_range(0, 1));
            div      = 16'($urandom_range(0, 3));
            load     = ($urandom_range(0, 15) == 0);
            load_val = 2'($urandom_range(0, 3));
            run_cycle();
        end
        load = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
